// File: rtl/i2c_slave_shift_if.sv
// i2c_slave_shift_if: pad and fabric signals of the I2C target bit engine
interface i2c_slave_shift_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] Tx_DATA;
  logic       Tx_Req;
  logic [7:0] Rx_DATA;
  logic       Rx_Valid;
  logic       Start_Det;
  logic       Stop_Det;
  logic       Addr_Match;
  logic       Rw_o;
  logic       Busy;
  logic       Nack_Rcvd;
  modport slave (
    input  scl_i, sda_i, Tx_DATA,
    output sda_oe, Tx_Req, Rx_DATA, Rx_Valid, Start_Det, Stop_Det,
           Addr_Match, Rw_o, Busy, Nack_Rcvd
  );
  modport master (
    output scl_i, sda_i, Tx_DATA,
    input  sda_oe, Tx_Req, Rx_DATA, Rx_Valid, Start_Det, Stop_Det,
           Addr_Match, Rw_o, Busy, Nack_Rcvd
  );
endinterface

// File: rtl/i2c_slave_shift.sv
// i2c_slave_shift: oversampled I2C target with address match, write deserializer and read serializer
module i2c_slave_shift #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input logic              Clk,
  input logic              Rst_n,
  i2c_slave_shift_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE} state_t;
  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);
  state_t     state;
  logic [1:0] scl_s, sda_s;
  logic [3:0] scl_n, sda_n;
  logic       scl_f, sda_f, scl_p, sda_p;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start    = scl_f & scl_p & ~sda_f & sda_p;
  assign stop     = scl_f & scl_p & sda_f & ~sda_p;
  // lines reset to the idle-high level so no false edge follows reset
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_n <= '0;
      sda_n <= '0;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], bus.scl_i};
      sda_s <= {sda_s[0], bus.sda_i};
      scl_n <= (scl_s[1] == scl_f || scl_n == LAST) ? '0 : scl_n + 4'd1;
      sda_n <= (sda_s[1] == sda_f || sda_n == LAST) ? '0 : sda_n + 4'd1;
      scl_f <= (scl_s[1] != scl_f && scl_n == LAST) ? scl_s[1] : scl_f;
      sda_f <= (sda_s[1] != sda_f && sda_n == LAST) ? sda_s[1] : sda_f;
      scl_p <= scl_f;
      sda_p <= sda_f;
    end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      bus.sda_oe     <= 1'b0;
      bus.Rx_DATA    <= 8'h00;
      bus.Rw_o       <= 1'b0;
      bus.Busy       <= 1'b0;
      bus.Tx_Req     <= 1'b0;
      bus.Rx_Valid   <= 1'b0;
      bus.Start_Det  <= 1'b0;
      bus.Stop_Det   <= 1'b0;
      bus.Addr_Match <= 1'b0;
      bus.Nack_Rcvd  <= 1'b0;
    end else begin
      bus.Tx_Req     <= 1'b0;
      bus.Rx_Valid   <= 1'b0;
      bus.Addr_Match <= 1'b0;
      bus.Nack_Rcvd  <= 1'b0;
      bus.Start_Det  <= start;
      bus.Stop_Det   <= stop;
      if (start || stop) begin
        state      <= start ? ADDR : IDLE;
        bus.sda_oe <= 1'b0;
        bus.Busy   <= 1'b0;
        bit_cnt    <= '0;
      end else
        case (state)
          ADDR:
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_f};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && shreg == SLAVE_ADDR) begin
                bus.Addr_Match <= 1'b1;
                bus.Rw_o       <= sda_f;
                bus.Busy       <= 1'b1;
              end else if (bit_cnt == 3'd7)
                state <= IGNORE;
            end else if (scl_fall && bus.Busy) begin
              bus.sda_oe <= 1'b1;
              state      <= ADDR_ACK;
            end
          ADDR_ACK:
            if (scl_fall) begin
              bus.Tx_Req <= bus.Rw_o;
              shreg      <= bus.Rw_o ? bus.Tx_DATA[6:0] : shreg;
              bus.sda_oe <= bus.Rw_o & ~bus.Tx_DATA[7];
              state      <= bus.Rw_o ? READ : WRITE;
            end
          WRITE:
            if (scl_rise) begin
              shreg        <= {shreg[5:0], sda_f};
              bit_cnt      <= bit_cnt + 3'd1;
              bus.Rx_DATA  <= bit_cnt == 3'd7 ? {shreg, sda_f} : bus.Rx_DATA;
              bus.Rx_Valid <= bit_cnt == 3'd7;
            end else if (scl_fall && bit_cnt == 3'd0) begin
              bus.sda_oe <= 1'b1;
              state      <= WR_ACK;
            end
          WR_ACK:
            if (scl_fall) begin
              bus.sda_oe <= 1'b0;
              state      <= WRITE;
            end
          READ:
            if (scl_fall) begin
              bit_cnt    <= bit_cnt + 3'd1;
              shreg      <= {shreg[5:0], 1'b0};
              bus.sda_oe <= bit_cnt != 3'd7 && !shreg[6];
              state      <= bit_cnt == 3'd7 ? RD_ACK : READ;
            end
          RD_ACK:
            if (scl_rise) begin
              shreg         <= {6'd0, sda_f};
              bus.Nack_Rcvd <= sda_f;
            end else if (scl_fall) begin
              bus.Tx_Req <= !shreg[0];
              bus.sda_oe <= !shreg[0] && !bus.Tx_DATA[7];
              shreg      <= shreg[0] ? shreg : bus.Tx_DATA[6:0];
              state      <= shreg[0] ? IGNORE : READ;
            end
          default: ;
        endcase
    end
endmodule

// File: doc/i2c_slave_shift.md
# i2c_slave_shift

I2C target (slave) bit engine: the responder end of the bus driven by our I2C master bit-shift engine. It oversamples raw SCL/SDA on the system clock and detects START, repeated START and STOP. It matches a 7-bit address, ACKs, and deserializes write bytes to the fabric. It serializes fabric-supplied bytes on master reads. It sits between the open-drain pad logic and the debugger's target-emulation register file.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit address this block responds to.
- FILTER_LEN, 3: consecutive equal synchronized samples required before a filtered line changes level (1..15).

- Clk  in  1  system clock (50 MHz nominal; must be ≥ 20× SCL rate)
- Rst_n  in  1  reset, asynchronous, active-low
- scl_i  in  1  raw SCL from pad
- sda_i  in  1  raw SDA from pad
- sda_oe  out  1  1 = pull SDA low; 0 = release (the block never drives high)
- Tx_DATA  in  8  next byte to send on a master read
- Tx_Req  out  1  one-cycle pulse; Tx_DATA is captured in this same cycle
- Rx_DATA  out  8  last byte written by master (register, held)
- Rx_Valid  out  1  one-cycle pulse when Rx_DATA updates
- Start_Det  out  1  one-cycle pulse on START or repeated START
- Stop_Det  out  1  one-cycle pulse on STOP
- Addr_Match  out  1  one-cycle pulse when the address byte matches
- Rw_o  out  1  R/W bit of the last matched address byte (1 = master read)
- Busy  out  1  high from Addr_Match until the next START/STOP
- Nack_Rcvd  out  1  one-cycle pulse when the master NACKs a read byte

## Operation
- Input path: 2-flop synchronizer per line, then a FILTER_LEN run-length filter producing scl_f/sda_f. Edge flags come from scl_f/sda_f versus their previous values.
- START: sda_f falls while scl_f = 1. STOP: sda_f rises while scl_f = 1. Both are recognized in every state, have priority over SCL-edge processing, release sda_oe, and clear bit count.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE.
- IDLE/IGNORE: sda_oe = 0. START → ADDR. STOP → IDLE.
- ADDR: shift sda_f on each SCL rise, MSB first, 8 bits. On the 8th rise:
  - Upper 7 bits == SLAVE_ADDR: pulse Addr_Match, latch Rw_o, set Busy. At the next SCL fall set sda_oe = 1 → ADDR_ACK.
  - Otherwise → IGNORE.
- ADDR_ACK: hold sda_oe through the ACK clock. At the SCL fall ending it:
  - Rw_o = 0: release → WRITE.
  - Rw_o = 1: capture Tx_DATA, pulse Tx_Req, sda_oe = ~bit7 → READ.
- WRITE: sample on SCL rises. On the 8th rise, update Rx_DATA and pulse Rx_Valid. At the next fall set sda_oe = 1 → WR_ACK. At the fall ending ACK, release → WRITE.
- READ: after each SCL fall, sda_oe = ~next bit. At the fall after bit 0, release → RD_ACK.
- RD_ACK: sample sda_f on SCL rise.
  - 0 (ACK): at the following fall, capture Tx_DATA, pulse Tx_Req, drive bit7 → READ.
  - 1 (NACK): pulse Nack_Rcvd; at the fall go to IGNORE.
- Bit counter is 3 bits and wraps 7→0 at byte end. Every byte is ACKed in WRITE; there is no flow-control NACK.
- No clock stretching and no general-call support.

## Timing
- Reset values: sda_oe 0, Rx_DATA 8'h00, Rw_o 0, Busy 0, all pulse outputs 0, state IDLE. Assertion of Rst_n releases sda_oe asynchronously, including mid-transfer.
- Pin-to-filtered latency: 2 + FILTER_LEN Clk cycles.
- sda_oe changes 1 Clk after the filtered SCL fall is detected. The filter delay provides the SDA hold time after SCL falls.
- Rx_Valid, Addr_Match and Nack_Rcvd are asserted 1 Clk after the detected SCL rise. Start_Det and Stop_Det are asserted 1 Clk after the detected SDA edge.
- Tx_DATA must be stable at the Tx_Req cycle. After Tx_Req, the fabric has one full byte time (9 SCL periods) to present the next byte.
- Glitches shorter than FILTER_LEN Clk cycles on either line have no effect.

## Test plan
- Write: START, 0xA0, 0x3C, 0x81, STOP →
  - ACK low on all 3 ACK clocks; Addr_Match once; Rw_o = 0.
  - Rx_Valid twice, with Rx_DATA 0x3C then 0x81.
  - Stop_Det pulses; Busy falls.
- Read: START, 0xA1, Tx_DATA = 0x5A then 0xC3, master ACK then NACK, STOP →
  - Bus carries 0x5A, 0xC3; Tx_Req pulses twice.
  - Nack_Rcvd once; sda_oe = 0 after the NACK.
- Mismatch: START, 0xA2, 0x11, STOP → sda_oe never 1; no Addr_Match and no Rx_Valid; Start_Det and Stop_Det each pulse once.
- Repeated START: START, 0xA0, 0x07, Sr, 0xA1, read 0x99 with NACK, STOP →
  - Start_Det twice; Rx_DATA = 0x07.
  - Rw_o changes 0→1; bus carries 0x99.
- Glitch: 2-Clk low pulse on sda_i while SCL is high (FILTER_LEN = 3) → no Start_Det, state unchanged.
- Reset mid-read: assert Rst_n low while sda_oe = 1 during bit 4 of 0x00 → sda_oe = 0 the same instant; outputs at reset values; the next START and 0xA0 are ACKed normally.
